// File: rtl/display_mode_scheduler.sv
// display_mode_scheduler: frame-synchronous owner of the shared OLED / seven-segment
// display mux. Source switches are accepted over valid/ready, take effect on an OLED
// frame boundary, and are followed by BLANK_FRAMES forced-black frames.
// Optional build macro: DISPLAY_SCHED_WATCHDOG_EN adds a cycle watchdog that stands in
// for a missing frame_begin after WDOG_CYCLES cycles in WAIT_FRAME or BLANK.
module display_mode_scheduler #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned BLANK_FRAMES = 2,
  parameter int unsigned WDOG_CYCLES  = 131072
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_begin,
  input  logic               req_valid,
  input  logic [1:0]         req_src,
  output logic               req_ready,
  input  logic [NUM_SRC-1:0] ended,
  output logic [1:0]         active_src,
  output logic               blank,
  output logic [NUM_SRC-1:0] src_enable,
  output logic               busy,
  output logic               req_err
);

  localparam int unsigned SRC_W  = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WDOG_W = 17;

  localparam logic [SRC_W:0]   NUM_SRC_L  = (SRC_W+1)'(NUM_SRC);
  localparam logic [CNT_W-1:0] BLANK_L    = CNT_W'(BLANK_FRAMES);
  localparam logic [NUM_SRC-1:0] MENU_EN  = NUM_SRC'(1);

  typedef enum logic [1:0] {
    ST_ACTIVE     = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_BLANK      = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SRC_W-1:0]   active_src_q, active_src_d;
  logic [SRC_W-1:0]   pending_src_q, pending_src_d;
  logic [CNT_W-1:0]   blank_cnt_q, blank_cnt_d;
  logic               blank_q, blank_d;
  logic [NUM_SRC-1:0] src_enable_q, src_enable_d;
  logic               busy_q, busy_d;
  logic               req_err_q, req_err_d;

  logic               ended_active;
  logic               wdog_fire;
  logic               frame_tick;

  // One-hot run enable for a source index.
  function automatic logic [NUM_SRC-1:0] onehot(input logic [SRC_W-1:0] idx);
    logic [NUM_SRC-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (idx == SRC_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Pick out the end pulse of the currently active source only.
  always_comb begin
    ended_active = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (active_src_q == SRC_W'(i)) ended_active = ended[i];
    end
  end

`ifdef DISPLAY_SCHED_WATCHDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;

  // Count cycles spent waiting on a frame; a missing frame_begin is synthesised at the limit.
  always_comb begin
    wdog_fire = (state_q != ST_ACTIVE) && (wdog_cnt_q == WDOG_LAST);
    if ((state_q == ST_ACTIVE) || frame_begin || wdog_fire) begin
      wdog_cnt_d = '0;
    end else begin
      wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wdog_cnt_q <= '0;
    else       wdog_cnt_q <= wdog_cnt_d;
  end
`else
  // Watchdog compiled out: frames come only from the OLED driver.
  assign wdog_fire = 1'b0 & (WDOG_CYCLES != 0);
`endif

  assign frame_tick = frame_begin | wdog_fire;

  // Next-state and next-output logic for the switch sequence.
  always_comb begin
    state_d       = state_q;
    active_src_d  = active_src_q;
    pending_src_d = pending_src_q;
    blank_cnt_d   = blank_cnt_q;
    blank_d       = blank_q;
    src_enable_d  = src_enable_q;
    req_err_d     = 1'b0;

    case (state_q)
      ST_ACTIVE: begin
        // An active source finishing returns to the menu and pre-empts any request.
        if (ended_active && (active_src_q != '0)) begin
          pending_src_d = '0;
          src_enable_d  = '0;
          state_d       = ST_WAIT_FRAME;
        end else if (req_valid) begin
          if ({1'b0, req_src} >= NUM_SRC_L) begin
            req_err_d = 1'b1;
          end else if (req_src != active_src_q) begin
            pending_src_d = req_src;
            src_enable_d  = '0;
            state_d       = ST_WAIT_FRAME;
          end
        end
      end

      ST_WAIT_FRAME: begin
        if (frame_tick) begin
          active_src_d = pending_src_q;
          blank_cnt_d  = '0;
          if (BLANK_FRAMES == 0) begin
            blank_d      = 1'b0;
            src_enable_d = onehot(pending_src_q);
            state_d      = ST_ACTIVE;
          end else begin
            blank_d = 1'b1;
            state_d = ST_BLANK;
          end
        end
      end

      ST_BLANK: begin
        if (frame_tick) begin
          blank_cnt_d = blank_cnt_q + CNT_W'(1);
          if ((blank_cnt_q + CNT_W'(1)) == BLANK_L) begin
            blank_d      = 1'b0;
            src_enable_d = onehot(active_src_q);
            state_d      = ST_ACTIVE;
          end
        end
      end

      default: begin
        state_d = ST_ACTIVE;
      end
    endcase

    busy_d = (state_d != ST_ACTIVE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_ACTIVE;
      active_src_q  <= '0;
      pending_src_q <= '0;
      blank_cnt_q   <= '0;
      blank_q       <= 1'b0;
      src_enable_q  <= MENU_EN;
      busy_q        <= 1'b0;
      req_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_src_q  <= active_src_d;
      pending_src_q <= pending_src_d;
      blank_cnt_q   <= blank_cnt_d;
      blank_q       <= blank_d;
      src_enable_q  <= src_enable_d;
      busy_q        <= busy_d;
      req_err_q     <= req_err_d;
    end
  end

  // Ready depends on state only so a requester never sees a loop through req_valid.
  assign req_ready  = (state_q == ST_ACTIVE) && !reset;
  assign active_src = active_src_q;
  assign blank      = blank_q;
  assign src_enable = src_enable_q;
  assign busy       = busy_q;
  assign req_err    = req_err_q;

endmodule

// File: tb/tb_display_mode_scheduler.sv
// Directed bench for display_mode_scheduler: a 4-source, 2-blank-frame instance and a
// 3-source, 0-blank-frame instance with a 64-cycle watchdog limit.
module tb_display_mode_scheduler;

  logic clk;
  logic reset;

  logic       fb4, rv4, rr4, bl4, by4, re4;
  logic [1:0] rs4, as4;
  logic [3:0] en4, se4;

  logic       fb3, rv3, rr3, bl3, by3, re3;
  logic [1:0] rs3, as3;
  logic [2:0] en3, se3;

  int total;
  int bad;

  display_mode_scheduler #(.NUM_SRC(4), .BLANK_FRAMES(2), .WDOG_CYCLES(131072)) u_dut4 (
    .clk(clk), .reset(reset), .frame_begin(fb4), .req_valid(rv4), .req_src(rs4),
    .req_ready(rr4), .ended(en4), .active_src(as4), .blank(bl4), .src_enable(se4),
    .busy(by4), .req_err(re4)
  );

  display_mode_scheduler #(.NUM_SRC(3), .BLANK_FRAMES(0), .WDOG_CYCLES(64)) u_dut3 (
    .clk(clk), .reset(reset), .frame_begin(fb3), .req_valid(rv3), .req_src(rs3),
    .req_ready(rr3), .ended(en3), .active_src(as3), .blank(bl3), .src_enable(se3),
    .busy(by3), .req_err(re3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fb4 = 0; rv4 = 0; rs4 = 0; en4 = 0;
    fb3 = 0; rv3 = 0; rs3 = 0; en3 = 0;
    run(2);
    reset = 1'b0;
    run(10);
    total++; if (as4 !== 2'd0) begin bad++; $display("FAIL reset_active_src got=%0h exp=0", as4); end
    total++; if (se4 !== 4'b0001) begin bad++; $display("FAIL reset_src_enable got=%b exp=0001", se4); end
    total++; if (bl4 !== 1'b0) begin bad++; $display("FAIL reset_blank got=%b exp=0", bl4); end
    total++; if (rr4 !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", rr4); end
    total++; if (by4 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", by4); end
    total++; if (re4 !== 1'b0) begin bad++; $display("FAIL reset_req_err got=%b exp=0", re4); end
    total++; if (se3 !== 3'b001) begin bad++; $display("FAIL reset_src_enable3 got=%b exp=001", se3); end
    total++; if (rr3 !== 1'b1) begin bad++; $display("FAIL reset_req_ready3 got=%b exp=1", rr3); end
  endtask

  task automatic test_switch();
    rv4 = 1'b1; rs4 = 2'd2;
    total++; if (rr4 !== 1'b1) begin bad++; $display("FAIL sw_ready_at_t got=%b exp=1", rr4); end
    step(); rv4 = 1'b0;                          // t+1
    total++; if (se4 !== 4'b0000) begin bad++; $display("FAIL sw_enable_t1 got=%b exp=0000", se4); end
    total++; if (by4 !== 1'b1) begin bad++; $display("FAIL sw_busy_t1 got=%b exp=1", by4); end
    total++; if (rr4 !== 1'b0) begin bad++; $display("FAIL sw_ready_t1 got=%b exp=0", rr4); end
    total++; if (as4 !== 2'd0) begin bad++; $display("FAIL sw_active_t1 got=%0h exp=0", as4); end
    run(4);                                      // t+5
    fb4 = 1'b1; step(); fb4 = 1'b0;              // t+6
    total++; if (as4 !== 2'd2) begin bad++; $display("FAIL sw_active_t6 got=%0h exp=2", as4); end
    total++; if (bl4 !== 1'b1) begin bad++; $display("FAIL sw_blank_t6 got=%b exp=1", bl4); end
    total++; if (se4 !== 4'b0000) begin bad++; $display("FAIL sw_enable_t6 got=%b exp=0000", se4); end
    run(99);                                     // t+105
    fb4 = 1'b1; step(); fb4 = 1'b0;              // t+106
    total++; if (bl4 !== 1'b1) begin bad++; $display("FAIL sw_blank_t106 got=%b exp=1", bl4); end
    run(99);                                     // t+205
    total++; if (by4 !== 1'b1) begin bad++; $display("FAIL sw_busy_t205 got=%b exp=1", by4); end
    fb4 = 1'b1; step(); fb4 = 1'b0;              // t+206
    total++; if (bl4 !== 1'b0) begin bad++; $display("FAIL sw_blank_t206 got=%b exp=0", bl4); end
    total++; if (se4 !== 4'b0100) begin bad++; $display("FAIL sw_enable_t206 got=%b exp=0100", se4); end
    total++; if (rr4 !== 1'b1) begin bad++; $display("FAIL sw_ready_t206 got=%b exp=1", rr4); end
    total++; if (by4 !== 1'b0) begin bad++; $display("FAIL sw_busy_t206 got=%b exp=0", by4); end
    total++; if (as4 !== 2'd2) begin bad++; $display("FAIL sw_active_t206 got=%0h exp=2", as4); end
  endtask

  task automatic test_ended_priority();
    en4 = 4'b0100; rv4 = 1'b1; rs4 = 2'd3;
    step(); en4 = 4'b0000;                       // request stays held
    total++; if (by4 !== 1'b1) begin bad++; $display("FAIL end_busy got=%b exp=1", by4); end
    total++; if (rr4 !== 1'b0) begin bad++; $display("FAIL end_ready got=%b exp=0", rr4); end
    total++; if (se4 !== 4'b0000) begin bad++; $display("FAIL end_enable got=%b exp=0000", se4); end
    run(3);
    fb4 = 1'b1; step(); fb4 = 1'b0;
    total++; if (as4 !== 2'd0) begin bad++; $display("FAIL end_target_menu got=%0h exp=0", as4); end
    total++; if (bl4 !== 1'b1) begin bad++; $display("FAIL end_blank got=%b exp=1", bl4); end
    run(3);
    fb4 = 1'b1; step(); fb4 = 1'b0;
    run(3);
    total++; if (rr4 !== 1'b0) begin bad++; $display("FAIL end_ready_in_blank got=%b exp=0", rr4); end
    fb4 = 1'b1; step(); fb4 = 1'b0;
    total++; if (se4 !== 4'b0001) begin bad++; $display("FAIL end_menu_enable got=%b exp=0001", se4); end
    total++; if (rr4 !== 1'b1) begin bad++; $display("FAIL end_ready_done got=%b exp=1", rr4); end
    total++; if (by4 !== 1'b0) begin bad++; $display("FAIL end_busy_done got=%b exp=0", by4); end
    step(); rv4 = 1'b0;                          // held request taken
    total++; if (by4 !== 1'b1) begin bad++; $display("FAIL held_req_busy got=%b exp=1", by4); end
    for (int k = 0; k < 3; k++) begin
      run(2);
      fb4 = 1'b1; step(); fb4 = 1'b0;
    end
    total++; if (as4 !== 2'd3) begin bad++; $display("FAIL held_req_active got=%0h exp=3", as4); end
    total++; if (se4 !== 4'b1000) begin bad++; $display("FAIL held_req_enable got=%b exp=1000", se4); end
    en4 = 4'b0111; step(); en4 = 4'b0000;        // other sources' end pulses
    total++; if (by4 !== 1'b0) begin bad++; $display("FAIL other_ended_busy got=%b exp=0", by4); end
    total++; if (se4 !== 4'b1000) begin bad++; $display("FAIL other_ended_enable got=%b exp=1000", se4); end
  endtask

  task automatic test_bad_src();
    rv3 = 1'b1; rs3 = 2'd3;
    step(); rv3 = 1'b0;
    total++; if (re3 !== 1'b1) begin bad++; $display("FAIL bad_req_err got=%b exp=1", re3); end
    total++; if (as3 !== 2'd0) begin bad++; $display("FAIL bad_active got=%0h exp=0", as3); end
    total++; if (by3 !== 1'b0) begin bad++; $display("FAIL bad_busy got=%b exp=0", by3); end
    total++; if (se3 !== 3'b001) begin bad++; $display("FAIL bad_enable got=%b exp=001", se3); end
    step();
    total++; if (re3 !== 1'b0) begin bad++; $display("FAIL bad_req_err_pulse got=%b exp=0", re3); end
    rv3 = 1'b1; rs3 = 2'd2;
    step(); rv3 = 1'b0;
    total++; if (by3 !== 1'b1) begin bad++; $display("FAIL nb_busy got=%b exp=1", by3); end
    total++; if (se3 !== 3'b000) begin bad++; $display("FAIL nb_enable got=%b exp=000", se3); end
    run(2);
    fb3 = 1'b1; step(); fb3 = 1'b0;
    total++; if (as3 !== 2'd2) begin bad++; $display("FAIL nb_active got=%0h exp=2", as3); end
    total++; if (se3 !== 3'b100) begin bad++; $display("FAIL nb_enable_done got=%b exp=100", se3); end
    total++; if (bl3 !== 1'b0) begin bad++; $display("FAIL nb_blank got=%b exp=0", bl3); end
    total++; if (by3 !== 1'b0) begin bad++; $display("FAIL nb_busy_done got=%b exp=0", by3); end
    en3 = 3'b010; step(); en3 = 3'b000;
    total++; if (by3 !== 1'b0) begin bad++; $display("FAIL nb_other_ended got=%b exp=0", by3); end
    rv3 = 1'b1; rs3 = 2'd2;
    step(); rv3 = 1'b0;
    total++; if (by3 !== 1'b0) begin bad++; $display("FAIL same_src_busy got=%b exp=0", by3); end
    total++; if (se3 !== 3'b100) begin bad++; $display("FAIL same_src_enable got=%b exp=100", se3); end
  endtask

  task automatic test_reset_mid_blank();
    rv4 = 1'b1; rs4 = 2'd1;
    step(); rv4 = 1'b0;
    step();
    fb4 = 1'b1; step(); fb4 = 1'b0;
    total++; if (bl4 !== 1'b1) begin bad++; $display("FAIL mid_blank_pre got=%b exp=1", bl4); end
    reset = 1'b1;
    step();
    total++; if (as4 !== 2'd0) begin bad++; $display("FAIL mid_rst_active got=%0h exp=0", as4); end
    total++; if (bl4 !== 1'b0) begin bad++; $display("FAIL mid_rst_blank got=%b exp=0", bl4); end
    total++; if (se4 !== 4'b0001) begin bad++; $display("FAIL mid_rst_enable got=%b exp=0001", se4); end
    total++; if (by4 !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", by4); end
    total++; if (rr4 !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0", rr4); end
    reset = 1'b0;
    step();
    total++; if (rr4 !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b exp=1", rr4); end
  endtask

  task automatic test_watchdog();
    logic stuck;
    rv3 = 1'b1; rs3 = 2'd1;
    step(); rv3 = 1'b0;                          // t+1
`ifdef DISPLAY_SCHED_WATCHDOG_EN
    stuck = 1'b0;
    run(63);                                     // t+64
    total++; if (by3 !== 1'b1) begin bad++; $display("FAIL wdog_busy_t64 got=%b exp=1", by3); end
    total++; if (as3 !== 2'd0) begin bad++; $display("FAIL wdog_active_t64 got=%0h exp=0", as3); end
    step();                                      // t+65
    total++; if (by3 !== 1'b0) begin bad++; $display("FAIL wdog_busy_t65 got=%b exp=0", by3); end
    total++; if (as3 !== 2'd1) begin bad++; $display("FAIL wdog_active_t65 got=%0h exp=1", as3); end
    total++; if (se3 !== 3'b010) begin bad++; $display("FAIL wdog_enable_t65 got=%b exp=010", se3); end
`else
    stuck = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      step();
      if (by3 !== 1'b1 || se3 !== 3'b000) stuck = 1'b0;
    end
    total++; if (stuck !== 1'b1) begin bad++; $display("FAIL nowdog_stuck got=%b exp=1", stuck); end
    total++; if (as3 !== 2'd0) begin bad++; $display("FAIL nowdog_active got=%0h exp=0", as3); end
    total++; if (rr3 !== 1'b0) begin bad++; $display("FAIL nowdog_ready got=%b exp=0", rr3); end
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_switch();
    test_ended_priority();
    test_bad_src();
    test_reset_mid_blank();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
